// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch controller states
//   Nop           : canonical RV32I no-op (addi x0, x0, 0)
//   PcIncrement   : byte distance between sequential instructions
package fetch_pkg;

    localparam int unsigned StateWidth = 2;
    localparam int unsigned WordWidth  = 32;

    typedef enum logic [StateWidth-1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    localparam logic [WordWidth-1:0] Nop         = 32'h0000_0013;
    localparam logic [WordWidth-1:0] PcIncrement = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
//   imem_req    : request valid, held until the response arrives
//   imem_addr   : request address, stable while a request is outstanding
//   imem_rvalid : response valid, completes the outstanding request
//   imem_rdata  : response data
// master = fetch unit side, slave = instruction memory side.
interface fetch_unit_if #(
    parameter int unsigned DataWidth = 32
) ();

    logic                 imem_req;
    logic [DataWidth-1:0] imem_addr;
    logic                 imem_rvalid;
    logic [DataWidth-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_hold_reg.sv
// Single-entry instruction/PC hold register; parks one memory response
// while decode is stalled.
//   clk, rst            : clock, synchronous active-high reset
//   load                : capture instr_in/pc_in
//   clear               : return to NOP/0 (wins over load)
//   instr_in, pc_in     : entry to capture
//   hold_instr, hold_pc : stored entry
module fetch_hold_reg
    import fetch_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [DataWidth-1:0] instr_in,
    input  logic [DataWidth-1:0] pc_in,
    output logic [DataWidth-1:0] hold_instr,
    output logic [DataWidth-1:0] hold_pc
);

    logic [DataWidth-1:0] instr_d, instr_q;
    logic [DataWidth-1:0] pc_d,    pc_q;

    // Next entry: clear beats load, otherwise keep.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            instr_d = DataWidth'(Nop);
            pc_d    = '0;
        end else if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= DataWidth'(Nop);
            pc_q    <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign hold_instr = instr_q;
    assign hold_pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, keeps one request in flight
// to instruction memory, presents instruction/PC/valid to decode, honours
// decode stalls and control-flow redirects.
//   clk, rst                 : clock, synchronous active-high reset
//   stall                    : decode cannot accept; hold current output
//   redirect, redirect_pc    : taken control transfer and its target
//   imem                     : instruction-memory channel (master side)
//   instruction, pc_address  : output to decode
//   valid                    : instruction/pc_address meaningful
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] ResetVector = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [DataWidth-1:0] redirect_pc,
    fetch_unit_if.master         imem,
    output logic [DataWidth-1:0] instruction,
    output logic [DataWidth-1:0] pc_address,
    output logic                 valid
);

    fetch_state_e         state_d,    state_q;
    logic [DataWidth-1:0] fetch_pc_d, fetch_pc_q;
    logic [DataWidth-1:0] req_pc_d,   req_pc_q;
    logic [DataWidth-1:0] instr_d,    instr_q;
    logic [DataWidth-1:0] pc_d,       pc_q;
    logic                 valid_d,    valid_q;
    logic                 imem_req_d, imem_req_q;

    logic [DataWidth-1:0] req_pc_inc;
    logic                 hold_load;
    logic                 hold_clear;
    logic [DataWidth-1:0] hold_instr;
    logic [DataWidth-1:0] hold_pc;

    fetch_hold_reg #(
        .DataWidth (DataWidth)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .clear      (hold_clear),
        .instr_in   (imem.imem_rdata),
        .pc_in      (req_pc_q),
        .hold_instr (hold_instr),
        .hold_pc    (hold_pc)
    );

    // Next-state, PC and output-register logic.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        req_pc_inc = req_pc_q + DataWidth'(PcIncrement);

        // Decode takes the current output; a load below overrides this.
        if (valid_q && !stall) begin
            valid_d = 1'b0;
        end

        if (redirect) begin
            valid_d    = 1'b0;
            hold_clear = 1'b1;
            fetch_pc_d = redirect_pc;
            case (state_q)
                FETCH: begin
                    // No response yet: the stale request must drain in FLUSH.
                    if (imem.imem_rvalid) begin
                        req_pc_d = redirect_pc;
                    end else begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    if (imem.imem_rvalid) begin
                        req_pc_d = redirect_pc;
                        state_d  = FETCH;
                    end
                end
                default: begin
                    req_pc_d = redirect_pc;
                    state_d  = FETCH;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    req_pc_d = fetch_pc_q;
                    state_d  = FETCH;
                end
                FETCH: begin
                    if (imem.imem_rvalid) begin
                        if (!valid_q || !stall) begin
                            instr_d    = imem.imem_rdata;
                            pc_d       = req_pc_q;
                            valid_d    = 1'b1;
                            fetch_pc_d = req_pc_inc;
                            req_pc_d   = req_pc_inc;
                        end else begin
                            // Output still occupied: park the response.
                            hold_load  = 1'b1;
                            fetch_pc_d = req_pc_inc;
                            state_d    = HOLD;
                        end
                    end
                end
                FLUSH: begin
                    if (imem.imem_rvalid) begin
                        req_pc_d = fetch_pc_q;
                        state_d  = FETCH;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d  = hold_instr;
                        pc_d     = hold_pc;
                        valid_d  = 1'b1;
                        req_pc_d = fetch_pc_q;
                        state_d  = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        imem_req_d = (state_d == FETCH) || (state_d == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= ResetVector;
            req_pc_q   <= ResetVector;
            instr_q    <= DataWidth'(Nop);
            pc_q       <= '0;
            valid_q    <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = req_pc_q;
    assign instruction    = instr_q;
    assign pc_address     = pc_q;
    assign valid          = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory model
// and a scoreboard of instructions decode is expected to consume.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] pc_address;
    logic        valid;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];

    // Memory model state
    int          lat;
    int          cnt;
    logic        busy;
    logic [31:0] addr_l;

    fetch_unit_if #(.DataWidth(32)) bus ();

    fetch_unit #(
        .DataWidth   (32),
        .ResetVector (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .instruction (instruction),
        .pc_address  (pc_address),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[23:0], 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Scoreboard: whatever decode consumes must be the next expected entry.
    task automatic mon_step();
        exp_t e;
        if (valid === 1'b1 && stall === 1'b0) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_out: observed pc=%h instr=%h expected none", pc_address, instruction);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", pc_address, e.pc);
                check("sb_instr", instruction, e.instr);
            end
        end
    endtask

    // Memory: accepts one request, answers after lat cycles.
    task automatic mem_step();
        if (rst) begin
            busy            = 1'b0;
            bus.imem_rvalid = 1'b0;
        end else begin
            if (bus.imem_rvalid) begin
                bus.imem_rvalid = 1'b0;
                busy            = 1'b0;
            end else if (busy) begin
                check("imem_req_held", 32'(bus.imem_req), 32'd1);
                check("imem_addr_held", bus.imem_addr, addr_l);
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(addr_l);
                end
            end
            if (!busy && bus.imem_req === 1'b1) begin
                busy   = 1'b1;
                addr_l = bus.imem_addr;
                cnt    = lat;
            end
        end
    endtask

    // One clock: monitor at negedge, memory at posedge+1, return at posedge+2.
    task automatic cycle();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
        mem_step();
        #1;
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] pc, input int max);
        int n = 0;
        while (!(valid === 1'b1 && pc_address === pc) && n < max) begin
            cycle();
            n++;
        end
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_pc"}, pc_address, pc);
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cycle();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_instr"}, instruction, Nop);
        check({tag, "_pc"}, pc_address, 32'd0);
        check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_addr"}, bus.imem_addr, 32'd0);
        check({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
        check({tag, "_hold_instr"}, dut.u_hold.instr_q, Nop);
        check({tag, "_hold_pc"}, dut.u_hold.pc_q, 32'd0);
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        lat             = 1;
        busy            = 1'b0;
        cnt             = 0;
        addr_l          = '0;

        repeat (3) cycle();
        check_reset("rst");

        // Single-cycle memory, first fetch from the reset vector
        push_exp(32'h0);
        rst = 1'b0;
        cycle();
        check("t1_req", 32'(bus.imem_req), 32'd1);
        check("t1_addr", bus.imem_addr, 32'h0);
        wait_pc("t1", 32'h0, 10);
        check("t1_instr", instruction, 32'h0050_0093);
        check("t1_next_addr", bus.imem_addr, 32'h4);
        cycle();
        rst = 1'b1;
        lat = 3;
        repeat (2) cycle();
        check("t1_drain", 32'(exp_q.size()), 32'd0);

        // Streaming, 3-cycle latency, no stall
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        push_exp(32'hC);
        rst = 1'b0;
        wait_drain("t2_drain", 80);
        rst = 1'b1;
        repeat (2) cycle();

        // Stall while the PC 8 response arrives
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        rst = 1'b0;
        wait_pc("t3_pc4", 32'h4, 40);
        stall = 1'b1;
        n = 0;
        while (bus.imem_req !== 1'b0 && n < 20) begin
            cycle();
            n++;
        end
        check("t3_req_low", 32'(bus.imem_req), 32'd0);
        check("t3_state", 32'(dut.state_q), 32'(HOLD));
        repeat (2) cycle();
        check("t3_hold_valid", 32'(valid), 32'd1);
        check("t3_hold_pc", pc_address, 32'h4);
        check("t3_hold_req", 32'(bus.imem_req), 32'd0);
        check("t3_holdreg_pc", dut.u_hold.pc_q, 32'h8);
        stall = 1'b0;
        cycle();
        check("t3_rel_valid", 32'(valid), 32'd1);
        check("t3_rel_pc", pc_address, 32'h8);
        check("t3_rel_instr", instruction, mem_word(32'h8));
        check("t3_rel_req", 32'(bus.imem_req), 32'd1);
        check("t3_rel_addr", bus.imem_addr, 32'hC);
        wait_pc("t3_pcC", 32'hC, 40);

        // Redirect coinciding with a response while stalled
        stall = 1'b1;
        n = 0;
        while (bus.imem_rvalid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check("t5_rvalid", 32'(bus.imem_rvalid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
        stall    = 1'b0;
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_state", 32'(dut.state_q), 32'(FETCH));
        check("t5_req", 32'(bus.imem_req), 32'd1);
        check("t5_addr", bus.imem_addr, 32'h200);
        check("t5_hold_instr", dut.u_hold.instr_q, Nop);
        check("t5_hold_pc", dut.u_hold.pc_q, 32'h0);
        push_exp(32'h200);

        // Redirect while the next request is outstanding
        wait_pc("t4_pc200", 32'h200, 40);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        check("t4_valid", 32'(valid), 32'd0);
        check("t4_state", 32'(dut.state_q), 32'(FLUSH));
        check("t4_stale_addr", bus.imem_addr, 32'h204);
        push_exp(32'h100);
        push_exp(32'h104);
        n = 0;
        while (bus.imem_addr !== 32'h100 && n < 20) begin
            cycle();
            n++;
        end
        check("t4_refetch_addr", bus.imem_addr, 32'h100);
        wait_drain("t4_drain", 60);

        // Reset while in FLUSH
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        cycle();
        redirect = 1'b0;
        check("t6_state", 32'(dut.state_q), 32'(FLUSH));
        rst = 1'b1;
        cycle();
        check_reset("t6_rst");
        push_exp(32'h0);
        rst = 1'b0;
        cycle();
        check("t6_restart_req", 32'(bus.imem_req), 32'd1);
        check("t6_restart_addr", bus.imem_addr, 32'h0);

        // PC wrap at the top of the address space
        wait_pc("t7_pc0", 32'h0, 20);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        cycle();
        redirect = 1'b0;
        wait_pc("t7_top", 32'hFFFF_FFFC, 40);
        check("t7_wrap_addr", bus.imem_addr, 32'h0);
        wait_drain("t7_drain", 60);
        stall = 1'b1;
        repeat (5) cycle();
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the RV32I pipeline. It owns the program counter and issues single-outstanding requests to instruction memory. It presents the fetched instruction, its PC and a valid flag to the decode stage, and it accepts stalls and control-flow redirects from later stages. A one-entry hold register absorbs a memory response that arrives while decode is stalled.

Parameters:
- DataWidth, 32, instruction/address width.
- ResetVector, 32'h0000_0000, first fetch address after reset.

Ports:
- clk, input, 1, clock; all state changes on its rising edge.
- rst, input, 1, synchronous reset, active-high.
- stall, input, 1, decode cannot accept; hold current output.
- redirect, input, 1, taken branch/jal/jalr; flush and refetch.
- redirect_pc, input, DataWidth, redirect target.
- imem_req, output, 1, request to instruction memory.
- imem_addr, output, DataWidth, request address; stable while imem_req=1 and no response.
- imem_rvalid, input, 1, response valid; completes the outstanding request.
- imem_rdata, input, DataWidth, response data.
- instruction, output, DataWidth, instruction to decode.
- pc_address, output, DataWidth, PC of instruction.
- valid, output, 1, instruction/pc_address meaningful.

Behaviour:
- Memory contract:
  - At most one request outstanding.
  - imem_req and imem_addr are held until the cycle imem_rvalid=1.
  - Response latency is >=1 cycle.
  - imem_rvalid is never asserted without an outstanding request.
- Registers:
  - fetch_pc: next address to fetch.
  - req_pc: outstanding address; drives imem_addr.
  - hold_instr and hold_pc.
  - Output registers.
  - State.
- Reset values (while rst=1, and after its last cycle):
  - state=IDLE, fetch_pc=req_pc=ResetVector.
  - valid=0, instruction=32'h0000_0013 (NOP), pc_address=0.
  - imem_req=0.
  - Hold registers: NOP/0.
- imem_req=1 exactly in states FETCH and FLUSH.
- Consume rule: the output is consumed in a cycle with valid=1 and stall=0. If nothing new is loaded that cycle, valid<=0.
- States and transitions:
  - IDLE: no request. Next state FETCH, with req_pc<=fetch_pc.
  - FETCH, imem_rvalid=1, output free (valid=0 or stall=0):
    - instruction<=imem_rdata, pc_address<=req_pc, valid<=1.
    - fetch_pc<=req_pc+4, req_pc<=req_pc+4.
    - Stay FETCH. Sustained throughput is one instruction per response.
  - FETCH, imem_rvalid=1, valid=1 and stall=1:
    - hold_instr<=imem_rdata, hold_pc<=req_pc.
    - fetch_pc<=req_pc+4.
    - Go to HOLD.
  - HOLD: no request.
    - When stall=0: instruction<=hold_instr, pc_address<=hold_pc, valid<=1, req_pc<=fetch_pc; go to FETCH.
  - FLUSH: request for a stale address remains outstanding. On imem_rvalid, discard the data, req_pc<=fetch_pc, go to FETCH.
- Redirect (priority over stall and over every rule above):
  - Always: valid<=0, the hold contents are discarded, fetch_pc<=redirect_pc.
  - FETCH with imem_rvalid=0: go to FLUSH; req_pc is unchanged.
  - FETCH with imem_rvalid=1: discard the response, req_pc<=redirect_pc, stay FETCH.
  - HOLD or IDLE: req_pc<=redirect_pc, go to FETCH.
  - FLUSH: the latest redirect_pc wins. If imem_rvalid=1, req_pc<=redirect_pc and go to FETCH; otherwise stay FLUSH.
- Arithmetic: PC increments are modulo 2^DataWidth, so 32'hFFFF_FFFC+4 wraps to 0. Redirect targets are not alignment-checked.
- rst asserted mid-request: the fetch unit returns to IDLE immediately. The memory must also be reset, so no orphan response is expected.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE, FETCH, FLUSH, HOLD);
  - the NOP constant 32'h0000_0013;
  - the PC increment constant 4.
- One natural sub-module: fetch_hold_reg, the single-entry instruction/pc hold register with load/clear.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 at address 0 -> imem_addr=0, then valid=1, instruction=32'h00500093, pc_address=0; next imem_addr=4.
- Streaming 3-cycle latency, 4 instructions, no stall -> pc_address 0,4,8,C in order; valid high one cycle per response.
- stall=1 held while the response for PC 8 arrives -> output holds PC 4, state HOLD, imem_req=0; stall release -> PC 8 presented the next cycle, then fetch resumes at 0xC.
- redirect to 0x100 while a request for 0x10 is outstanding -> valid=0 next cycle; the 0x10 response is dropped; the next imem_addr is 0x100.
- redirect to 0x200 in the same cycle as imem_rvalid with stall=1 -> no instruction presented and the hold register is cleared; the next request is 0x200.
- rst pulsed while in FLUSH -> all outputs at reset values; fetch restarts at ResetVector after IDLE.
